// File: rtl/ecc_job_arbiter.sv
// Round-robin front end for one ECC point-multiplier engine: grants one
// requester at a time, sequences engine reset/enable/run and returns x/y.
module ecc_job_arbiter #(
  parameter int NREQ       = 4,
  parameter int W          = 163,
  parameter int RST_CYC    = 2,
  parameter int TMO_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   req_k,
  output logic [NREQ-1:0]     ack,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2:0]          res_id,
  output logic [W-1:0]        res_x,
  output logic [W-1:0]        res_y,
  output logic                res_err,
  output logic                eng_rst,
  output logic                eng_enable,
  output logic [W-1:0]        eng_din,
  input  logic                eng_done,
  input  logic [W-1:0]        eng_dx,
  input  logic [W-1:0]        eng_dy,
  output logic                busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              res_valid_q, res_valid_d;
  logic [2:0]        res_id_q, res_id_d;
  logic [W-1:0]      res_x_q, res_x_d, res_y_q, res_y_d, din_q, din_d;
  logic              res_err_q, res_err_d;

  logic              found;
  logic [2:0]        gsel;
  logic [IW-1:0]     idx;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        gsel  = 3'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_err_q   <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_err_q   <= res_err_d;
      din_q       <= din_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_err_d   = res_err_q;
    din_d       = din_q;
    case (state_q)
      S_IDLE: if (found) begin
        ack_d    = NREQ'(1) << gsel;
        res_id_d = gsel;
        ptr_d    = (gsel == 3'(NREQ - 1)) ? 3'd0 : gsel + 3'd1;
        cnt_d    = '0;
        state_d  = S_RST;
        for (int i = 0; i < NREQ; i++)
          if (gsel == 3'(i)) din_d = req_k[i*W +: W];
      end
      S_RST: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 16'd1;
        // First three RUN cycles may see a stale done from the engine's registers.
        if (eng_done && cnt_q >= 16'd3) begin
          res_x_d     = eng_dx;
          res_y_d     = eng_dy;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == TMO_LAST) begin
          res_x_d     = '0;
          res_y_d     = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Engine is held in reset whenever it is not actively running a job.
  always_comb begin
    eng_rst    = (state_q != S_RUN);
    eng_enable = (state_q == S_RUN);
    busy       = (state_q != S_IDLE);
  end

  assign ack       = ack_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_err   = res_err_q;
  assign eng_din   = din_q;
endmodule

// File: tb/tb_ecc_job_arbiter.sv
// Directed bench for ecc_job_arbiter: reset, fairness, single job, stale done,
// backpressure, mid-run reset and timeout (second instance with short timeout).
module tb_ecc_job_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 163;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_a = '0, req_t = '0;
  logic [W-1:0]      kv [NREQ];
  logic [NREQ*W-1:0] req_k;
  logic              res_ready = 1'b0, eng_done = 1'b0;
  logic [W-1:0]      eng_dx = '0, eng_dy = '0;

  logic [NREQ-1:0] ack_a, ack_t;
  logic            res_valid_a, res_valid_t, res_err_a, res_err_t;
  logic [2:0]      res_id_a, res_id_t;
  logic [W-1:0]    res_x_a, res_y_a, res_x_t, res_y_t, eng_din_a, eng_din_t;
  logic            eng_rst_a, eng_rst_t, eng_en_a, eng_en_t, busy_a, busy_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] pm = 2'd0;

  always_comb begin
    req_k = '0;
    for (int i = 0; i < NREQ; i++) req_k[i*W +: W] = kv[i];
  end

  ecc_job_arbiter #(.NREQ(NREQ), .W(W), .RST_CYC(2), .TMO_CYCLES(65535)) dut (
    .clk(clk), .rst(rst), .req(req_a), .req_k(req_k), .ack(ack_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_id(res_id_a),
    .res_x(res_x_a), .res_y(res_y_a), .res_err(res_err_a),
    .eng_rst(eng_rst_a), .eng_enable(eng_en_a), .eng_din(eng_din_a),
    .eng_done(eng_done), .eng_dx(eng_dx), .eng_dy(eng_dy), .busy(busy_a));

  ecc_job_arbiter #(.NREQ(NREQ), .W(W), .RST_CYC(2), .TMO_CYCLES(50)) dut_t (
    .clk(clk), .rst(rst), .req(req_t), .req_k(req_k), .ack(ack_t),
    .res_valid(res_valid_t), .res_ready(res_ready), .res_id(res_id_t),
    .res_x(res_x_t), .res_y(res_y_t), .res_err(res_err_t),
    .eng_rst(eng_rst_t), .eng_enable(eng_en_t), .eng_din(eng_din_t),
    .eng_done(eng_done), .eng_dx(eng_dx), .eng_dy(eng_dy), .busy(busy_t));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] j;
    for (int i = 0; i < 4; i++) begin
      j = p + 2'(i);
      if (r[j]) return j;
    end
    return p;
  endfunction

  // Waits for the grant, checks it, drops that req, then waits for the result.
  task automatic job(input logic [1:0] g, input logic [W-1:0] dx);
    bit ok;
    eng_dx = dx;
    eng_dy = ~dx;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (ack_a != '0) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok || ack_a !== (4'd1 << g)) begin
      n_fail++; $display("FAIL job_ack: got %b expected %b", ack_a, 4'd1 << g);
    end
    n_chk++;
    if (eng_din_a !== kv[g] || res_id_a !== {1'b0, g}) begin
      n_fail++; $display("FAIL job_din: got din %h id %0d expected %h id %0d", eng_din_a, res_id_a, kv[g], g);
    end
    req_a = req_a & ~(4'd1 << g);
    pm = g + 2'd1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (res_valid_a) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok || res_id_a !== {1'b0, g} || res_x_a !== dx || res_y_a !== ~dx || res_err_a !== 1'b0) begin
      n_fail++; $display("FAIL job_res: got v %b id %0d x %h err %b expected id %0d x %h", res_valid_a, res_id_a, res_x_a, res_err_a, g, dx);
    end
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    n_chk++;
    if ({ack_a, res_valid_a, res_id_a, res_err_a, eng_rst_a, eng_en_a, busy_a} !== {4'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", {ack_a, res_valid_a, res_id_a, res_err_a, eng_rst_a, eng_en_a, busy_a}, 12'b000000000100);
    end
    n_chk++;
    if ((res_x_a | res_y_a | eng_din_a) !== '0 || {res_valid_t, eng_rst_t, busy_t} !== 3'b010) begin
      n_fail++; $display("FAIL reset_data: got x %h din %h t %b expected 0 0 010", res_x_a, eng_din_a, {res_valid_t, eng_rst_t, busy_t});
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_fairness;
    logic [1:0] g;
    eng_done = 1'b1; res_ready = 1'b1;
    req_a = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      g = rr_pick(req_a, pm);
      n_chk++;
      if (g !== 2'(n)) begin n_fail++; $display("FAIL fair_model: got %0d expected %0d", g, n); end
      job(g, W'(163'h700 + n));
    end
    req_a = 4'b0011;
    job(rr_pick(req_a, pm), 163'h710);
    job(rr_pick(req_a, pm), 163'h711);
    n_chk++;
    if (pm !== 2'd2) begin n_fail++; $display("FAIL fair_ptr: got %0d expected 2", pm); end
  endtask

  task automatic test_single;
    bit early;
    eng_done = 1'b0; res_ready = 1'b0;
    kv[0] = 163'h5;
    req_a = 4'b0001;
    tick;
    n_chk++;
    if (ack_a !== 4'b0001 || eng_din_a !== 163'h5 || eng_rst_a !== 1'b1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL single_ack: got ack %b din %h rst %b expected 0001 5 1", ack_a, eng_din_a, eng_rst_a);
    end
    req_a = '0;
    tick;
    n_chk++;
    if (ack_a !== 4'b0 || eng_en_a !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse: got ack %b en %b expected 0000 0", ack_a, eng_en_a);
    end
    tick;
    n_chk++;
    if (eng_en_a !== 1'b1 || eng_rst_a !== 1'b0) begin
      n_fail++; $display("FAIL single_enable: got en %b rst %b expected 1 0", eng_en_a, eng_rst_a);
    end
    early = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (res_valid_a) early = 1;
    end
    eng_done = 1'b1; eng_dx = 163'hA; eng_dy = 163'hB;
    tick;
    eng_done = 1'b0;
    n_chk++;
    if (early || res_valid_a !== 1'b1 || res_id_a !== 3'd0 || res_x_a !== 163'hA || res_y_a !== 163'hB || res_err_a !== 1'b0 || eng_rst_a !== 1'b1 || eng_en_a !== 1'b0) begin
      n_fail++; $display("FAIL single_res: got early %b v %b x %h y %h err %b expected 0 1 a b 0", early, res_valid_a, res_x_a, res_y_a, res_err_a);
    end
    res_ready = 1'b1;
    tick;
    n_chk++;
    if (busy_a !== 1'b0 || res_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got busy %b v %b expected 0 0", busy_a, res_valid_a);
    end
    pm = 2'd1;
  endtask

  task automatic test_stale_done;
    bit early;
    eng_done = 1'b1; eng_dx = 163'hC; eng_dy = 163'hD; res_ready = 1'b1;
    req_a = 4'b0010;
    tick;
    n_chk++;
    if (ack_a !== 4'b0010) begin n_fail++; $display("FAIL stale_ack: got %b expected 0010", ack_a); end
    req_a = '0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (res_valid_a) early = 1;
    end
    n_chk++;
    if (early) begin n_fail++; $display("FAIL stale_early: got valid before run cycle 3 expected none"); end
    tick;
    n_chk++;
    if (res_valid_a !== 1'b1 || res_x_a !== 163'hC || res_id_a !== 3'd1) begin
      n_fail++; $display("FAIL stale_cap: got v %b x %h id %0d expected 1 c 1", res_valid_a, res_x_a, res_id_a);
    end
    tick;
    pm = 2'd2;
  endtask

  task automatic test_backpressure;
    int bad;
    eng_done = 1'b1; res_ready = 1'b0;
    req_a = 4'b0100;
    job_wait_valid: begin
      tick;
      n_chk++;
      if (ack_a !== 4'b0100) begin n_fail++; $display("FAIL bp_ack: got %b expected 0100", ack_a); end
      req_a = '0;
      for (int i = 0; i < 5; i++) tick;
    end
    eng_dx = 163'hE;
    tick;
    eng_dx = 163'hF;
    req_a = 4'b1111;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (res_valid_a !== 1'b1 || res_x_a !== 163'hE || res_id_a !== 3'd2 || ack_a !== 4'b0 || eng_rst_a !== 1'b1 || busy_a !== 1'b1) begin
        n_fail++; bad++;
        if (bad < 3) $display("FAIL bp_hold: got v %b x %h ack %b rst %b expected 1 e 0000 1", res_valid_a, res_x_a, ack_a, eng_rst_a);
      end
      tick;
    end
    res_ready = 1'b1; req_a = '0;
    tick;
    tick;
    n_chk++;
    if (res_valid_a !== 1'b0 || busy_a !== 1'b0 || ack_a !== 4'b0) begin
      n_fail++; $display("FAIL bp_release: got v %b busy %b ack %b expected 0 0 0000", res_valid_a, busy_a, ack_a);
    end
    pm = 2'd3;
  endtask

  task automatic test_reset_mid_run;
    eng_done = 1'b0;
    req_a = 4'b0010;
    tick;
    n_chk++;
    if (ack_a !== 4'b0010) begin n_fail++; $display("FAIL mr_ack: got %b expected 0010", ack_a); end
    req_a = '0;
    tick; tick;
    for (int i = 0; i < 10; i++) tick;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({ack_a, res_valid_a, res_id_a, eng_rst_a, eng_en_a, busy_a} !== {4'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0} || eng_din_a !== '0) begin
      n_fail++; $display("FAIL mr_async: got %b din %h expected 00000000100 0", {ack_a, res_valid_a, res_id_a, eng_rst_a, eng_en_a, busy_a}, eng_din_a);
    end
    tick;
    rst = 1'b1;
    pm = 2'd0;
    eng_done = 1'b1; res_ready = 1'b1;
    req_a = 4'b1111;
    job(rr_pick(req_a, pm), 163'h99);
    req_a = '0;
    tick;
  endtask

  task automatic test_timeout;
    bit early;
    eng_done = 1'b0; eng_dx = 163'h1234; eng_dy = 163'h5678; res_ready = 1'b0;
    req_t = 4'b0001;
    tick;
    n_chk++;
    if (ack_t !== 4'b0001) begin n_fail++; $display("FAIL tmo_ack: got %b expected 0001", ack_t); end
    req_t = '0;
    tick; tick;
    early = 0;
    for (int i = 0; i < 49; i++) begin
      if (res_valid_t) early = 1;
      tick;
    end
    n_chk++;
    if (early || res_valid_t !== 1'b0 || eng_en_t !== 1'b1) begin
      n_fail++; $display("FAIL tmo_early: got early %b v %b en %b expected 0 0 1", early, res_valid_t, eng_en_t);
    end
    tick;
    n_chk++;
    if (res_valid_t !== 1'b1 || res_err_t !== 1'b1 || res_x_t !== '0 || res_y_t !== '0 || eng_rst_t !== 1'b1 || res_id_t !== 3'd0) begin
      n_fail++; $display("FAIL tmo_res: got v %b err %b x %h y %h rst %b expected 1 1 0 0 1", res_valid_t, res_err_t, res_x_t, res_y_t, eng_rst_t);
    end
    res_ready = 1'b1;
    tick;
    n_chk++;
    if (res_valid_t !== 1'b0 || busy_t !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: got v %b busy %b expected 0 0", res_valid_t, busy_t);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) kv[i] = W'(163'h100 + i);
    test_reset;
    test_fairness;
    test_single;
    test_stale_done;
    test_backpressure;
    test_reset_mid_run;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
